pc_fetch_sequencer: RTL

- Owns the program counter and sequences instruction fetch for the CPU front end.
- Issues one fetch at a time to instruction memory over a req/ack handshake and computes the sequential PC+4 internally.
- Applies branch/jump redirects and trap vectoring, and holds one fetched instruction in an output slot until the decode stage accepts it.
- Sits between instruction memory and decode; replaces the bare PC register plus PC+4 adder.

---
 rtl/pc_fetch_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer.
// Handles redirect/trap flush, drain of an in-flight fetch, halt, and a one-entry output slot.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap,
    input  logic        halt,
    output logic        align_err,
    output logic        halted,
    output logic [1:0]  dbg_state
);

    // Memory handshake: a transfer completes in any cycle where imem_req=1 and
    // imem_ack=1; once imem_req rises it and imem_addr hold until that cycle.
    // Decode handshake: the slot transfers in any cycle where inst_valid=1 and stall=0.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        valid_q, valid_d;
    logic        align_q, align_d;

    logic        accept;
    logic        redir;
    logic [31:0] tgt_pc;
    logic        req;
    logic        pending;
    logic [31:0] fetch_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            req_q     <= 1'b0;
            addr_q    <= RESET_PC;
            inst_q    <= 32'h0;
            inst_pc_q <= 32'h0;
            valid_q   <= 1'b0;
            align_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            align_q   <= align_d;
        end
    end

    always_comb begin
        accept     = valid_q && !stall;
        redir      = (state_q != S_HALTED) && (trap || redirect_valid);
        tgt_pc     = trap ? TRAP_VEC : {redirect_pc[31:2], 2'b00};
        // An in-flight request keeps its captured address even after pc moves on.
        fetch_addr = req_q ? addr_q : pc_q;

        req = 1'b0;
        if (state_q == S_FETCH) begin
            req = req_q || (!halt && (!valid_q || accept));
        end else if (state_q == S_DRAIN) begin
            req = 1'b1;
        end
        pending = req && !imem_ack;

        state_d   = state_q;
        pc_d      = pc_q;
        req_d     = 1'b0;
        addr_d    = addr_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q && !accept;
        align_d   = redir && !trap && (redirect_pc[1:0] != 2'b00);

        case (state_q)
            S_IDLE: begin
                state_d = halt ? S_HALTED : S_FETCH;
            end
            S_FETCH: begin
                req_d = pending;
                if (pending) begin
                    addr_d = fetch_addr;
                end
                if (req && imem_ack && !redir) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = fetch_addr;
                    valid_d   = 1'b1;
                    pc_d      = fetch_addr + 32'd4;
                end
                if (redir && pending) begin
                    state_d = S_DRAIN;
                end else if (halt && !pending) begin
                    state_d = S_HALTED;
                end
            end
            S_DRAIN: begin
                req_d = pending;
                if (!pending) begin
                    state_d = halt ? S_HALTED : S_FETCH;
                end
            end
            default: begin
            end
        endcase

        // Flush wins over both a fresh load and a stalled slot.
        if (redir) begin
            pc_d    = tgt_pc;
            valid_d = 1'b0;
        end
    end

    assign imem_req   = req;
    assign imem_addr  = fetch_addr;
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign pc_plus4   = inst_pc_q + 32'd4;
    assign align_err  = align_q;
    assign halted     = (state_q == S_HALTED);
    assign dbg_state  = state_q;

endmodule
